// File: rtl/wir_ctrl.sv
// Wrapper instruction register, bypass register and mode decoder for the wrapped core.
// Shifts/updates the serial WIR, decodes it into boundary-cell mode controls and muxes WSO.
module wir_ctrl #(
  parameter int unsigned WIR_W = 4
) (
  input  logic WRCK,
  input  logic RESET,
  input  logic WSI,
  input  logic SelectWIR,
  input  logic ShiftWR,
  input  logic CaptureWR,
  input  logic UpdateWR,
  input  logic wbr_so,
  output logic WSO,
  output logic wir_extest,
  output logic wir_wpc,
  output logic wir_wbr_concat,
  output logic extest,
  output logic hold_inputs,
  output logic hold_outputs,
  output logic scanmode,
  output logic mbistmode,
  output logic bus_disable,
  output logic wbr_concat,
  output logic wpp_bypass,
  output logic wby_shift,
  output logic wse_inputs,
  output logic wse_outputs,
  output logic se
);

  localparam logic [WIR_W-1:0] OP_EXTEST = WIR_W'(4'b0001);
  localparam logic [WIR_W-1:0] OP_INTEST = WIR_W'(4'b0010);
  localparam logic [WIR_W-1:0] OP_SCAN   = WIR_W'(4'b0011);
  localparam logic [WIR_W-1:0] OP_MBIST  = WIR_W'(4'b0100);
  localparam logic [WIR_W-1:0] OP_CLAMP  = WIR_W'(4'b0101);
  localparam logic [WIR_W-1:0] OP_SAFE   = WIR_W'(4'b0110);
  localparam logic [WIR_W-1:0] OP_WPBYP  = WIR_W'(4'b0111);
  localparam logic [WIR_W-1:0] OP_CONCAT = WIR_W'(4'b1000);
  localparam logic [WIR_W-1:0] OP_WPC    = WIR_W'(4'b1001);

  logic [WIR_W-1:0] wir_sr_q, wir_sr_d;
  logic [WIR_W-1:0] wir_ur_q, wir_ur_d;
  logic             wby_q, wby_d;
  logic             wby_path;
  logic             data_shift;

  // Update always samples the pre-edge shift stage; capture wins over shift.
  always_comb begin
    wir_sr_d = wir_sr_q;
    wir_ur_d = wir_ur_q;
    wby_d    = wby_q;
    if (SelectWIR) begin
      if (CaptureWR) begin
        wir_sr_d = wir_ur_q;
      end else if (ShiftWR) begin
        wir_sr_d = {WSI, wir_sr_q[WIR_W-1:1]};
      end
      if (UpdateWR) begin
        wir_ur_d = wir_sr_q;
      end
    end else if (wby_path) begin
      if (CaptureWR) begin
        wby_d = 1'b0;
      end else if (ShiftWR) begin
        wby_d = WSI;
      end
    end
  end

  always_ff @(posedge WRCK) begin
    if (RESET) begin
      wir_sr_q <= '0;
      wir_ur_q <= '0;
      wby_q    <= 1'b0;
    end else begin
      wir_sr_q <= wir_sr_d;
      wir_ur_q <= wir_ur_d;
      wby_q    <= wby_d;
    end
  end

  // Unlisted opcodes fall through to the bypass decode.
  always_comb begin
    wir_extest     = 1'b0;
    wir_wpc        = 1'b0;
    wir_wbr_concat = 1'b0;
    extest         = 1'b0;
    hold_inputs    = 1'b0;
    hold_outputs   = 1'b0;
    scanmode       = 1'b0;
    mbistmode      = 1'b0;
    bus_disable    = 1'b0;
    wbr_concat     = 1'b0;
    wpp_bypass     = 1'b0;
    wby_path       = 1'b1;
    case (wir_ur_q)
      OP_EXTEST: begin
        wir_extest  = 1'b1;
        extest      = 1'b1;
        hold_inputs = 1'b1;
        wby_path    = 1'b0;
      end
      OP_INTEST: begin
        hold_outputs = 1'b1;
        scanmode     = 1'b1;
        wby_path     = 1'b0;
      end
      OP_SCAN:  scanmode   = 1'b1;
      OP_MBIST: mbistmode  = 1'b1;
      OP_CLAMP: hold_outputs = 1'b1;
      OP_SAFE: begin
        hold_outputs = 1'b1;
        bus_disable  = 1'b1;
      end
      OP_WPBYP: wpp_bypass = 1'b1;
      OP_CONCAT: begin
        wir_wbr_concat = 1'b1;
        wbr_concat     = 1'b1;
        scanmode       = 1'b1;
        wby_path       = 1'b0;
      end
      OP_WPC:   wir_wpc    = 1'b1;
      default:  ;
    endcase
  end

  assign data_shift  = ShiftWR & ~SelectWIR;
  assign wby_shift   = data_shift & wby_path;
  assign wse_inputs  = data_shift & ~wby_path;
  assign wse_outputs = data_shift & ~wby_path;
  assign se          = data_shift & scanmode;

  assign WSO = SelectWIR ? wir_sr_q[0] : (wby_path ? wby_q : wbr_so);

endmodule

// File: tb/tb_wir_ctrl.sv
// Self-checking bench for wir_ctrl: instruction-level model compared every cycle,
// plus directed loads with hand-computed literal expectations.
module tb_wir_ctrl;

  logic WRCK = 1'b0;
  logic RESET = 1'b1;
  logic WSI = 1'b0, SelectWIR = 1'b0, ShiftWR = 1'b0, CaptureWR = 1'b0, UpdateWR = 1'b0;
  logic wbr_so = 1'b0;
  logic WSO, wir_extest, wir_wpc, wir_wbr_concat, extest, hold_inputs, hold_outputs;
  logic scanmode, mbistmode, bus_disable, wbr_concat, wpp_bypass;
  logic wby_shift, wse_inputs, wse_outputs, se;

  wir_ctrl #(.WIR_W(4)) dut (
    .WRCK(WRCK), .RESET(RESET), .WSI(WSI), .SelectWIR(SelectWIR), .ShiftWR(ShiftWR),
    .CaptureWR(CaptureWR), .UpdateWR(UpdateWR), .wbr_so(wbr_so), .WSO(WSO),
    .wir_extest(wir_extest), .wir_wpc(wir_wpc), .wir_wbr_concat(wir_wbr_concat),
    .extest(extest), .hold_inputs(hold_inputs), .hold_outputs(hold_outputs),
    .scanmode(scanmode), .mbistmode(mbistmode), .bus_disable(bus_disable),
    .wbr_concat(wbr_concat), .wpp_bypass(wpp_bypass), .wby_shift(wby_shift),
    .wse_inputs(wse_inputs), .wse_outputs(wse_outputs), .se(se)
  );

  always #5 WRCK = ~WRCK;

  // Static flag order: wir_extest wir_wpc wir_wbr_concat extest hold_inputs
  // hold_outputs scanmode mbistmode bus_disable wbr_concat wpp_bypass
  localparam logic [10:0] F_NONE   = 11'b00000000000;
  localparam logic [10:0] F_EXTEST = 11'b10011000000;
  localparam logic [10:0] F_INTEST = 11'b00000110000;
  localparam logic [10:0] F_SCAN   = 11'b00000010000;
  localparam logic [10:0] F_MBIST  = 11'b00000001000;
  localparam logic [10:0] F_CLAMP  = 11'b00000100000;
  localparam logic [10:0] F_SAFE   = 11'b00000100100;
  localparam logic [10:0] F_WPBYP  = 11'b00000000001;
  localparam logic [10:0] F_CONCAT = 11'b00100010010;
  localparam logic [10:0] F_WPC    = 11'b01000000000;

  logic [10:0] stat;
  logic [15:0] dut_vec;
  assign stat = {wir_extest, wir_wpc, wir_wbr_concat, extest, hold_inputs, hold_outputs,
                 scanmode, mbistmode, bus_disable, wbr_concat, wpp_bypass};
  assign dut_vec = {stat, wby_shift, wse_inputs, wse_outputs, se, WSO};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction table: flags and whether the boundary register is the data path.
  logic [10:0] tbl_flags [16];
  logic        tbl_wbr   [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl_flags[i] = F_NONE;
      tbl_wbr[i]   = 1'b0;
    end
    tbl_flags[1] = F_EXTEST; tbl_wbr[1] = 1'b1;
    tbl_flags[2] = F_INTEST; tbl_wbr[2] = 1'b1;
    tbl_flags[3] = F_SCAN;
    tbl_flags[4] = F_MBIST;
    tbl_flags[5] = F_CLAMP;
    tbl_flags[6] = F_SAFE;
    tbl_flags[7] = F_WPBYP;
    tbl_flags[8] = F_CONCAT; tbl_wbr[8] = 1'b1;
    tbl_flags[9] = F_WPC;
  end

  // Model: active instruction, pending shift contents, bypass bit.
  int   m_sr = 0, m_ur = 0;
  logic m_wby = 1'b0;
  logic m_valid = 1'b0;

  always @(posedge WRCK) begin
    int nsr, nur;
    logic nwby;
    nsr = m_sr; nur = m_ur; nwby = m_wby;
    if (RESET) begin
      nsr = 0; nur = 0; nwby = 1'b0;
      m_valid = 1'b1;
    end else if (SelectWIR) begin
      if (CaptureWR) nsr = m_ur;
      else if (ShiftWR) nsr = (m_sr / 2) + (WSI ? 8 : 0);
      if (UpdateWR) nur = m_sr;
    end else if (!tbl_wbr[m_ur]) begin
      if (CaptureWR) nwby = 1'b0;
      else if (ShiftWR) nwby = WSI;
    end
    m_sr = nsr; m_ur = nur; m_wby = nwby;
  end

  always @(negedge WRCK) begin
    logic wbr, dsh, wso;
    logic [15:0] exp;
    if (m_valid) begin
      wbr = tbl_wbr[m_ur];
      dsh = ShiftWR & ~SelectWIR;
      wso = SelectWIR ? logic'(m_sr % 2) : (wbr ? wbr_so : m_wby);
      exp = {tbl_flags[m_ur], dsh & ~wbr, dsh & wbr, dsh & wbr, dsh & tbl_flags[m_ur][4], wso};
      chk("model", dut_vec, exp);
    end
  end

  task automatic set_in(input logic sel, input logic sh, input logic cap, input logic upd,
                        input logic wsi);
    SelectWIR = sel; ShiftWR = sh; CaptureWR = cap; UpdateWR = upd; WSI = wsi;
    #1;
  endtask

  task automatic tick();
    @(posedge WRCK);
    #1;
  endtask

  task automatic load(input logic [3:0] op);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, op[i]);
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] rb_exp;
    logic [3:0] shift_pat;
    logic [3:0] wso_exp;

    // Reset then idle.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("reset_flags", 16'(stat), 16'(F_NONE));
    chk("reset_wso", 16'(WSO), 16'h0);

    // EXTEST load and boundary-register shift path.
    load(4'b0001);
    chk("extest_flags", 16'(stat), 16'(F_EXTEST));
    wbr_so = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("extest_wse", 16'({wse_inputs, wse_outputs, wby_shift}), 16'b110);
    chk("extest_wso_hi", 16'(WSO), 16'h1);
    wbr_so = 1'b0;
    #1;
    chk("extest_wso_lo", 16'(WSO), 16'h0);
    tick();

    // Bypass: capture then shift 1,0,1,1; WSO lags by one cycle through wby.
    load(4'b0000);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("byp_cap_noshift", 16'(wby_shift), 16'h0);
    tick();
    shift_pat = 4'b1101;
    wso_exp   = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0, shift_pat[i]);
      chk("byp_shift_wso", 16'({wby_shift, WSO}), 16'({1'b1, wso_exp[i]}));
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("byp_idle_noshift", 16'(wby_shift), 16'h0);

    // WS_SAFE readback through WSO while flags hold.
    load(4'b0110);
    chk("safe_flags", 16'(stat), 16'(F_SAFE));
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    rb_exp = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("safe_readback", 16'({stat, WSO}), 16'({F_SAFE, rb_exp[i]}));
      tick();
    end
    load(4'b1101);
    chk("reserved_flags", 16'(stat), 16'(F_NONE));
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reserved_path", 16'({wby_shift, wse_inputs, se}), 16'b100);
    tick();

    // Reset in the middle of a new load discards it.
    load(4'b1000);
    chk("concat_flags", 16'(stat), 16'(F_CONCAT));
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    RESET = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    RESET = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midreset_all", dut_vec, 16'h0);
    load(4'b0011);
    chk("scan_flags", 16'(stat), 16'(F_SCAN));
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("scan_se_on", 16'(se), 16'h1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("scan_se_off", 16'(se), 16'h0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("scan_se_wirsel", 16'(se), 16'h0);

    // Capture beats shift; update samples pre-shift contents.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cap_over_shift", 16'(WSO), 16'h1);
    shift_pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, shift_pat[i]);
      tick();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("upd_preshift", 16'(stat), 16'(F_CLAMP));

    // Remaining opcodes through the model.
    load(4'b0100);
    chk("mbist_flags", 16'(stat), 16'(F_MBIST));
    load(4'b0111);
    chk("wpbyp_flags", 16'(stat), 16'(F_WPBYP));
    load(4'b1001);
    chk("wpc_flags", 16'(stat), 16'(F_WPC));
    load(4'b0010);
    chk("intest_flags", 16'(stat), 16'(F_INTEST));
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wir_ctrl.md
# wir_ctrl

Wrapper instruction register and mode decoder for the IEEE 1500 wrapped example core. It sits directly upstream of the wrapped core: it shifts and updates the serial wrapper instruction, holds the bypass register, and drives all wrapper/boundary-cell mode controls. It also muxes the serial wrapper output (WSO) from the WIR, the WBY or the core's `wbr_so`.

## Interface
Parameters:
- `WIR_W`, 4: WIR length in bits; opcodes below assume 4.

Ports:
- `WRCK` in 1: wrapper clock, all flops rising-edge.
- `RESET` in 1: synchronous, active-high reset.
- `WSI` in 1: serial wrapper input.
- `SelectWIR` in 1: 1 = WIR is the active serial path.
- `ShiftWR`, `CaptureWR`, `UpdateWR` in 1 each: WSC shift/capture/update enables.
- `wbr_so` in 1: serial output of the wrapped core's boundary register.
- `WSO` out 1: serial wrapper output.
- `wir_extest`, `wir_wpc`, `wir_wbr_concat` out 1 each: raw instruction flags.
- `extest`, `hold_inputs`, `hold_outputs`, `scanmode`, `mbistmode`, `bus_disable`, `wbr_concat`, `wpp_bypass` out 1 each: static mode controls.
- `wby_shift`, `wse_inputs`, `wse_outputs`, `se` out 1 each: shift-gated controls.

## Operation
Registers:
- `wir_sr[WIR_W-1:0]` (shift stage).
- `wir_ur[WIR_W-1:0]` (update stage).
- `wby` (1-bit bypass).

WIR path (SelectWIR=1):
- `CaptureWR`: `wir_sr <= wir_ur` (readback).
- `ShiftWR`: `wir_sr <= {WSI, wir_sr[WIR_W-1:1]}`. LSB goes out first.
- `UpdateWR`: `wir_ur <= wir_sr`.

Data path (SelectWIR=0):
- Bypass instruction: `CaptureWR` → `wby <= 0`; `ShiftWR` → `wby <= WSI`.
- `wir_sr` and `wir_ur` hold.

Simultaneous enables:
- CaptureWR has priority over ShiftWR.
- UpdateWR samples the pre-edge `wir_sr`, independent of a same-cycle shift or capture.

Opcode decode, combinational from `wir_ur`. Flags not listed are 0.
- 0000 WS_BYPASS: none; WBY path.
- 0001 WS_EXTEST: `wir_extest`, `extest`, `hold_inputs`; WBR path.
- 0010 WS_INTEST: `hold_outputs`, `scanmode`; WBR path.
- 0011 WP_SCAN: `scanmode`; WBY path.
- 0100 WP_MBIST: `mbistmode`; WBY path.
- 0101 WS_CLAMP: `hold_outputs`; WBY path.
- 0110 WS_SAFE: `hold_outputs`, `bus_disable`; WBY path.
- 0111 WP_BYPASS: `wpp_bypass`; WBY path.
- 1000 WS_CONCAT: `wir_wbr_concat`, `wbr_concat`, `scanmode`; WBR path.
- 1001 WP_WPC: `wir_wpc`; WBY path.
- 1010–1111: decode identical to 0000.

Shift-gated outputs:
- `wby_shift` = ShiftWR & ~SelectWIR & WBY-path.
- `wse_inputs` = `wse_outputs` = ShiftWR & ~SelectWIR & WBR-path.
- `se` = ShiftWR & ~SelectWIR & `scanmode`.

WSO mux, combinational:
- SelectWIR=1: `wir_sr[0]`.
- Otherwise, WBY-path: `wby`.
- Otherwise: `wbr_so`.

## Timing
- Reset: `wir_sr`, `wir_ur` and `wby` are cleared to 0. This decodes to WS_BYPASS, so every mode output is 0. WSO reads `wir_sr[0]` or `wby`, both 0.
- Reset mid-shift or mid-update discards the partial instruction. The cycle after RESET deasserts is an ordinary cycle.
- Instruction latency: mode outputs change immediately after the WRCK edge that samples UpdateWR=1, with zero extra pipeline.
- Shift-gated outputs follow ShiftWR/SelectWIR in the same cycle and are combinational.
- A WIR load needs exactly WIR_W shift cycles, then one update cycle. Extra shift cycles keep shifting; the last WIR_W bits win.
- WSO is valid from the rising edge and is consumed at the next rising edge. No falling-edge retiming inside this block.
- Capture/Shift/Update with SelectWIR=1 never alter `wby`. With SelectWIR=0 they never alter `wir_sr`/`wir_ur`.

## Test plan
- Reset, then idle 5 cycles: all mode outputs 0, WSO=0, `wir_ur`=0000.
- SelectWIR=1, shift WSI bits 1,0,0,0 (LSB first) over 4 cycles, then UpdateWR: the cycle after update, `extest`=`wir_extest`=`hold_inputs`=1 and all other flags 0. With SelectWIR=0, ShiftWR=1: `wse_inputs`=`wse_outputs`=1 and WSO follows `wbr_so`.
- Load 0000, SelectWIR=0, CaptureWR, then shift pattern 1,0,1,1: WSO shows 0,1,0,1 (one-cycle delay via `wby`); `wby_shift`=1 only during shift.
- Load 0110, then read back (CaptureWR+4×ShiftWR with SelectWIR=1): WSO emits 0,1,1,0 while outputs stay `hold_outputs`=`bus_disable`=1. Load 1101: decode equals bypass, all flags 0.
- Load 1000, then assert RESET during the 2nd shift cycle of a new load: all outputs return to 0 the next cycle, and a subsequent full load of 0011 gives `scanmode`=1; `se`=1 only while ShiftWR=1 and SelectWIR=0.
- Assert CaptureWR and ShiftWR together with SelectWIR=1: `wir_sr` takes the captured value, not the shifted one. UpdateWR with ShiftWR in the same cycle: `wir_ur` takes the pre-shift value.
